// File: rtl/ldlt_decomp.sv
// ldlt_decomp: fixed-point LDL^T factorizer for a symmetric 6x6 matrix.
// A shared multiplier and a shared divider run column by column under a
// fixed schedule. The right-hand side rides along unchanged for the solver.
// Ports:
//   i_clk, i_rst_n (async, active-low), i_start (one-cycle request)
//   i_A_ij  lower triangle of A (j <= i), i_Vec_k right-hand side
//   o_done  one-cycle pulse when outputs are valid, o_div_zero zero pivot seen
//   o_Mat_ii D_i, o_Mat_ij L_ij (i > j), o_Vec_k captured right-hand side
//
// state | meaning
// IDLE  | waiting for i_start, outputs hold last result
// BUSY  | stepping load / MAC / divide; the final step pulses o_done

package RgbdVoConfigPk;
  localparam int MATRIX_BW = 32;
  localparam int MUL       = 16;
endpackage

module ldlt_decomp
  import RgbdVoConfigPk::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [MATRIX_BW-1:0] i_A_00, i_A_10, i_A_11, i_A_20, i_A_21, i_A_22,
  input  logic [MATRIX_BW-1:0] i_A_30, i_A_31, i_A_32, i_A_33,
  input  logic [MATRIX_BW-1:0] i_A_40, i_A_41, i_A_42, i_A_43, i_A_44,
  input  logic [MATRIX_BW-1:0] i_A_50, i_A_51, i_A_52, i_A_53, i_A_54, i_A_55,
  input  logic [MATRIX_BW-1:0] i_Vec_0, i_Vec_1, i_Vec_2, i_Vec_3, i_Vec_4, i_Vec_5,
  output logic                 o_done,
  output logic                 o_div_zero,
  output logic [MATRIX_BW-1:0] o_Mat_00, o_Mat_11, o_Mat_22, o_Mat_33, o_Mat_44, o_Mat_55,
  output logic [MATRIX_BW-1:0] o_Mat_10, o_Mat_20, o_Mat_21, o_Mat_30, o_Mat_31,
  output logic [MATRIX_BW-1:0] o_Mat_32, o_Mat_40, o_Mat_41, o_Mat_42, o_Mat_43,
  output logic [MATRIX_BW-1:0] o_Mat_50, o_Mat_51, o_Mat_52, o_Mat_53, o_Mat_54,
  output logic [MATRIX_BW-1:0] o_Vec_0, o_Vec_1, o_Vec_2, o_Vec_3, o_Vec_4, o_Vec_5
);
  localparam int W = MATRIX_BW;
  localparam logic signed [2*W-1:0] RND_BIAS = {{(2*W-MUL){1'b0}}, {MUL{1'b1}}};
  localparam logic signed [2*W-1:0] ZERO2    = '0;

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {S_LOAD, S_MAC, S_DIV, S_DONE} step_t;

  // Packed lower triangle including the diagonal: (i,j) -> i(i+1)/2 + j
  function automatic logic [4:0] tri_idx(input logic [2:0] i, input logic [2:0] j);
    logic [4:0] ii;
    ii = {2'b00, i};
    return ((ii * (ii + 5'd1)) >> 1) + {2'b00, j};
  endfunction

  // Strictly lower triangle (i > j): (i,j) -> i(i-1)/2 + j
  function automatic logic [4:0] low_idx(input logic [2:0] i, input logic [2:0] j);
    logic [4:0] ii;
    ii = {2'b00, i};
    return ((ii * (ii - 5'd1)) >> 1) + {2'b00, j};
  endfunction

  // Drop MUL fraction bits rounding toward zero: bias negatives before the shift
  function automatic logic signed [W-1:0] rnd_prod(input logic signed [2*W-1:0] p);
    return W'($signed(p + (p[2*W-1] ? RND_BIAS : ZERO2)) >>> MUL);
  endfunction

  logic [W-1:0] a_in [21];
  logic [W-1:0] v_in [6];
  assign a_in = '{i_A_00, i_A_10, i_A_11, i_A_20, i_A_21, i_A_22, i_A_30, i_A_31, i_A_32,
                  i_A_33, i_A_40, i_A_41, i_A_42, i_A_43, i_A_44, i_A_50, i_A_51, i_A_52,
                  i_A_53, i_A_54, i_A_55};
  assign v_in = '{i_Vec_0, i_Vec_1, i_Vec_2, i_Vec_3, i_Vec_4, i_Vec_5};

  state_t               state_q;
  step_t                step_q;
  logic [1:0]           ph_q;
  logic [2:0]           col_q, row_q, k_q;
  logic [W-1:0]         a_q [21];
  logic [W-1:0]         vec_q [6];
  logic [W-1:0]         d_q [6];
  logic [W-1:0]         e_q [15];
  logic [W-1:0]         l_q [15];
  logic signed [W-1:0]  acc_q, mul_a_q, mul_b_q;
  logic signed [2*W-1:0] prod_q, num_q, den_q;
  logic [W-1:0]         quo_q, quo2_q;
  logic                 dz_q;
  logic [W-1:0]         od_q [6];
  logic [W-1:0]         ol_q [15];
  logic [W-1:0]         ov_q [6];
  logic                 done_q, dz_out_q;

  logic signed [W-1:0]  v_d;
  logic                 val_rdy, adv;

  // v_d is the element value on the cycle it completes: the raw A entry when a
  // column-0 element has no MAC terms, otherwise the accumulator after the
  // final subtract. adv marks the last cycle of an element.
  always_comb begin
    v_d     = (step_q == S_LOAD) ? $signed(a_q[tri_idx(row_q, col_q)]) : acc_q - rnd_prod(prod_q);
    val_rdy = (state_q == BUSY) &&
              (((step_q == S_LOAD) && (col_q == 3'd0)) ||
               ((step_q == S_MAC) && (ph_q == 2'd2) && (k_q == col_q - 3'd1)));
    adv     = (val_rdy && (row_q == col_q)) ||
              ((state_q == BUSY) && (step_q == S_DIV) && (ph_q == 2'd3));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;  step_q <= S_LOAD;  ph_q <= '0;
      col_q <= '0;  row_q <= '0;  k_q <= '0;
      acc_q <= '0;  mul_a_q <= '0;  mul_b_q <= '0;  prod_q <= '0;
      num_q <= '0;  den_q <= '0;  quo_q <= '0;  quo2_q <= '0;
      dz_q <= 1'b0;  done_q <= 1'b0;  dz_out_q <= 1'b0;
      for (int n = 0; n < 21; n++) a_q[n] <= '0;
      for (int n = 0; n < 15; n++) begin
        e_q[n] <= '0;  l_q[n] <= '0;  ol_q[n] <= '0;
      end
      for (int n = 0; n < 6; n++) begin
        vec_q[n] <= '0;  d_q[n] <= '0;  od_q[n] <= '0;  ov_q[n] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (i_start) begin
          for (int n = 0; n < 21; n++) a_q[n] <= a_in[n];
          for (int n = 0; n < 6; n++) vec_q[n] <= v_in[n];
          dz_q <= 1'b0;  dz_out_q <= 1'b0;
          state_q <= BUSY;  step_q <= S_LOAD;  ph_q <= '0;
          col_q <= '0;  row_q <= '0;  k_q <= '0;
        end
        BUSY: begin
          case (step_q)
            S_LOAD: begin
              acc_q <= v_d;
              k_q   <= '0;
              ph_q  <= '0;
              if (!val_rdy) step_q <= S_MAC;
            end
            S_MAC: begin
              ph_q <= ph_q + 2'd1;
              case (ph_q)
                2'd0: begin
                  mul_a_q <= l_q[low_idx(row_q, k_q)];
                  mul_b_q <= e_q[low_idx(col_q, k_q)];
                end
                2'd1: prod_q <= {{W{mul_a_q[W-1]}}, mul_a_q} * {{W{mul_b_q[W-1]}}, mul_b_q};
                default: begin
                  acc_q <= v_d;
                  k_q   <= k_q + 3'd1;
                  ph_q  <= '0;
                end
              endcase
            end
            S_DIV: begin
              ph_q <= ph_q + 2'd1;
              case (ph_q)
                2'd0: begin
                  num_q <= {{(W-MUL){acc_q[W-1]}}, acc_q, {MUL{1'b0}}};
                  den_q <= {{W{d_q[col_q][W-1]}}, d_q[col_q]};
                end
                2'd1: quo_q  <= (den_q != ZERO2) ? W'(num_q / den_q) : '0;
                2'd2: quo2_q <= quo_q;
                default: begin
                  l_q[low_idx(row_q, col_q)] <= (den_q == ZERO2) ? '0 : quo2_q;
                  dz_q <= dz_q | (den_q == ZERO2);
                end
              endcase
            end
            default: begin
              state_q <= IDLE;
              step_q  <= S_LOAD;
            end
          endcase

          if (val_rdy) begin
            acc_q <= v_d;
            if (row_q == col_q) d_q[col_q] <= v_d;
            else begin
              e_q[low_idx(row_q, col_q)] <= v_d;
              step_q <= S_DIV;
              ph_q   <= '0;
            end
          end

          if (adv) begin
            k_q  <= '0;
            ph_q <= '0;
            if (row_q != 3'd5) begin
              row_q  <= row_q + 3'd1;
              step_q <= S_LOAD;
            end else if (col_q != 3'd5) begin
              col_q  <= col_q + 3'd1;
              row_q  <= col_q + 3'd1;
              step_q <= S_LOAD;
            end else begin
              // D_5 is being written on this same edge, so take it from v_d
              step_q <= S_DONE;
              done_q <= 1'b1;
              for (int n = 0; n < 5; n++) od_q[n] <= d_q[n];
              od_q[5] <= v_d;
              for (int n = 0; n < 15; n++) ol_q[n] <= l_q[n];
              for (int n = 0; n < 6; n++) ov_q[n] <= vec_q[n];
              dz_out_q <= dz_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_done     = done_q;
  assign o_div_zero = dz_out_q;
  assign o_Mat_00 = od_q[0];  assign o_Mat_11 = od_q[1];  assign o_Mat_22 = od_q[2];
  assign o_Mat_33 = od_q[3];  assign o_Mat_44 = od_q[4];  assign o_Mat_55 = od_q[5];
  assign o_Mat_10 = ol_q[0];  assign o_Mat_20 = ol_q[1];  assign o_Mat_21 = ol_q[2];
  assign o_Mat_30 = ol_q[3];  assign o_Mat_31 = ol_q[4];  assign o_Mat_32 = ol_q[5];
  assign o_Mat_40 = ol_q[6];  assign o_Mat_41 = ol_q[7];  assign o_Mat_42 = ol_q[8];
  assign o_Mat_43 = ol_q[9];  assign o_Mat_50 = ol_q[10]; assign o_Mat_51 = ol_q[11];
  assign o_Mat_52 = ol_q[12]; assign o_Mat_53 = ol_q[13]; assign o_Mat_54 = ol_q[14];
  assign o_Vec_0 = ov_q[0];   assign o_Vec_1 = ov_q[1];   assign o_Vec_2 = ov_q[2];
  assign o_Vec_3 = ov_q[3];   assign o_Vec_4 = ov_q[4];   assign o_Vec_5 = ov_q[5];

endmodule
